// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, hazard FSM states, pipeline latencies
// and the decode helpers used by the hazard logic and the decoder.
package cpu_pkg;

  localparam int unsigned NUM_REGS         = 16;
  localparam int unsigned REG_IDX_W        = 4;
  localparam int unsigned CNT_W            = 3;
  localparam int unsigned ALU_LAT_DEF      = 3;
  localparam int unsigned LD_LAT_DEF       = 4;
  localparam int unsigned FLUSH_CYCLES_DEF = 2;

  // 1101-1111 are unassigned and act as no-source, non-writing ops
  typedef enum logic [3:0] {
    OP_SUB  = 4'd0,
    OP_ADD  = 4'd1,
    OP_LSL  = 4'd2,
    OP_NEG  = 4'd3,
    OP_MOVI = 4'd4,
    OP_CMP  = 4'd5,
    OP_MOVR = 4'd6,
    OP_LDR  = 4'd7,
    OP_STR  = 4'd8,
    OP_BEQ  = 4'd9,
    OP_BGT  = 4'd10,
    OP_BLT  = 4'd11,
    OP_B    = 4'd12
  } opcode_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic uses_rs1(input logic [3:0] op);
    case (op)
      OP_SUB, OP_ADD, OP_CMP, OP_BEQ, OP_BGT, OP_BLT, OP_STR,
      OP_LSL, OP_NEG, OP_MOVR, OP_LDR: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    case (op)
      OP_SUB, OP_ADD, OP_CMP, OP_BEQ, OP_BGT, OP_BLT, OP_STR: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

  function automatic logic is_writer(input logic [3:0] op);
    case (op)
      OP_SUB, OP_ADD, OP_LSL, OP_NEG, OP_MOVI, OP_CMP, OP_MOVR, OP_LDR: return 1'b1;
      default:                                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register write-pending countdowns; busy_vec flags every register whose
// result is not yet readable.
module hazard_scoreboard
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic [REG_IDX_W-1:0] load_idx,
  input  logic [CNT_W-1:0]     load_val,
  output logic [NUM_REGS-1:0]  busy_vec
);

  logic [CNT_W-1:0] count_q [NUM_REGS];

  // A load on the same edge as a decrement takes precedence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) count_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load_en && (load_idx == REG_IDX_W'(i))) begin
          count_q[i] <= load_val;
        end else if (count_q[i] != '0) begin
          count_q[i] <= count_q[i] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) busy_vec[i] = (count_q[i] != '0);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Decode-stage hazard controller: stalls on RAW/WAW against the scoreboard and
// flushes the front end for a fixed number of cycles after a taken branch.
module pipeline_hazard_controller
  import cpu_pkg::*;
#(
  parameter int unsigned ALU_LAT      = ALU_LAT_DEF,
  parameter int unsigned LD_LAT       = LD_LAT_DEF,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [3:0]           id_opcode,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 ex_branch_taken,
  output logic                 stall_pc,
  output logic                 stall_ifid,
  output logic                 flush_ifid,
  output logic                 bubble_idex,
  output logic                 issue,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic [1:0]           state
);

  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e          state_q, state_n, cur_state;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_n;
  logic            hazard;
  logic            load_en;
  logic [CNT_W-1:0] load_val;

  hazard_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .load_idx (id_rd),
    .load_val (load_val),
    .busy_vec (busy_vec)
  );

  // RAW on any used source, or WAW on the destination of a writer
  always_comb begin
    hazard = id_valid &&
             ((uses_rs1(id_opcode) && busy_vec[id_rs1]) ||
              (uses_rs2(id_opcode) && busy_vec[id_rs2]) ||
              (is_writer(id_opcode) && busy_vec[id_rd]));
    load_val = (id_opcode == OP_LDR) ? CNT_W'(LD_LAT) : CNT_W'(ALU_LAT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_n;
      flush_cnt_q <= flush_cnt_n;
    end
  end

  // cur_state is the mode in effect this cycle; flush beats stall
  always_comb begin
    state_n     = RUN;
    flush_cnt_n = flush_cnt_q;
    cur_state   = RUN;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    issue       = 1'b0;
    load_en     = 1'b0;

    if (ex_branch_taken) begin
      cur_state   = FLUSH;
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
      flush_cnt_n = FW'(FLUSH_CYCLES - 1);
      state_n     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (state_q == FLUSH) begin
      cur_state   = FLUSH;
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
      flush_cnt_n = flush_cnt_q - FW'(1);
      state_n     = (flush_cnt_q > FW'(1)) ? FLUSH : RUN;
    end else if (hazard) begin
      cur_state   = STALL;
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      bubble_idex = 1'b1;
      state_n     = STALL;
    end else begin
      issue   = id_valid;
      load_en = id_valid && is_writer(id_opcode);
    end

    if (rst) begin
      cur_state   = RUN;
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      flush_ifid  = 1'b0;
      bubble_idex = 1'b0;
      issue       = 1'b0;
      load_en     = 1'b0;
    end
  end

  assign state = 2'(cur_state);

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed vector bench for pipeline_hazard_controller: one table row per clock
// cycle plus hand-driven sequences around asynchronous reset.
module tb_pipeline_hazard_controller;
  import cpu_pkg::*;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_opcode, id_rs1, id_rs2, id_rd;
  logic        ex_branch_taken;
  logic        stall_pc, stall_ifid, flush_ifid, bubble_idex, issue;
  logic [15:0] busy_vec;
  logic [1:0]  state;

  int n_vec  = 0;
  int n_miss = 0;

  pipeline_hazard_controller dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_opcode       (id_opcode),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .ex_branch_taken (ex_branch_taken),
    .stall_pc        (stall_pc),
    .stall_ifid      (stall_ifid),
    .flush_ifid      (flush_ifid),
    .bubble_idex     (bubble_idex),
    .issue           (issue),
    .busy_vec        (busy_vec),
    .state           (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        v;
    logic [3:0]  op, rs1, rs2, rd;
    logic        br;
    logic        stall, flush, bubble, iss;
    logic [15:0] busy;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic r, input logic v,
                     input logic [3:0] op, input logic [3:0] rs1,
                     input logic [3:0] rs2, input logic [3:0] rd, input logic br,
                     input logic stall, input logic flush, input logic bubble,
                     input logic iss, input logic [15:0] busy, input logic [1:0] st);
    vec_t t;
    t.name = name; t.rst = r; t.v = v; t.op = op; t.rs1 = rs1; t.rs2 = rs2;
    t.rd = rd; t.br = br; t.stall = stall; t.flush = flush; t.bubble = bubble;
    t.iss = iss; t.busy = busy; t.st = st;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] op,
                       input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic br);
    rst = r; id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2;
    id_rd = rd; ex_branch_taken = br;
  endtask

  task automatic check(input string name, input logic e_stall, input logic e_flush,
                       input logic e_bubble, input logic e_iss,
                       input logic [15:0] e_busy, input logic [1:0] e_st);
    n_vec++;
    if ({stall_pc, stall_ifid, flush_ifid, bubble_idex, issue, busy_vec, state} !==
        {e_stall, e_stall, e_flush, e_bubble, e_iss, e_busy, e_st}) begin
      n_miss++;
      $display("FAIL %s: got stall_pc=%b stall_ifid=%b flush=%b bubble=%b issue=%b busy=%h state=%0d; want stall=%b flush=%b bubble=%b issue=%b busy=%h state=%0d",
               name, stall_pc, stall_ifid, flush_ifid, bubble_idex, issue, busy_vec, state,
               e_stall, e_flush, e_bubble, e_iss, e_busy, e_st);
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

    //   name           rst v  op       rs1 rs2 rd  br  stl fl bub iss busy      state
    add("rst_gate",     1, 1, OP_ADD,  2,  3,  1,  1,  0, 0, 0, 0, 16'h0000, S_RUN);
    add("add_r1",       0, 1, OP_ADD,  2,  3,  1,  0,  0, 0, 0, 1, 16'h0000, S_RUN);
    add("raw_t1",       0, 1, OP_SUB,  1,  3,  2,  0,  1, 0, 1, 0, 16'h0002, S_STALL);
    add("raw_t2",       0, 1, OP_SUB,  1,  3,  2,  0,  1, 0, 1, 0, 16'h0002, S_STALL);
    add("raw_t3",       0, 1, OP_SUB,  1,  3,  2,  0,  1, 0, 1, 0, 16'h0002, S_STALL);
    add("raw_issue",    0, 1, OP_SUB,  1,  3,  2,  0,  0, 0, 0, 1, 16'h0000, S_RUN);
    add("ldr_r4",       0, 1, OP_LDR,  0,  0,  4,  0,  0, 0, 0, 1, 16'h0004, S_RUN);
    add("ld_use_t1",    0, 1, OP_ADD,  4,  4,  5,  0,  1, 0, 1, 0, 16'h0014, S_STALL);
    add("ld_use_t2",    0, 1, OP_ADD,  4,  4,  5,  0,  1, 0, 1, 0, 16'h0014, S_STALL);
    add("ld_use_t3",    0, 1, OP_ADD,  4,  4,  5,  0,  1, 0, 1, 0, 16'h0010, S_STALL);
    add("ld_use_t4",    0, 1, OP_ADD,  4,  4,  5,  0,  1, 0, 1, 0, 16'h0010, S_STALL);
    add("ld_use_issue", 0, 1, OP_ADD,  4,  4,  5,  0,  0, 0, 0, 1, 16'h0000, S_RUN);
    add("movi_r6",      0, 1, OP_MOVI, 0,  0,  6,  0,  0, 0, 0, 1, 16'h0020, S_RUN);
    add("waw_t1",       0, 1, OP_MOVI, 0,  0,  6,  0,  1, 0, 1, 0, 16'h0060, S_STALL);
    add("waw_t2",       0, 1, OP_MOVI, 0,  0,  6,  0,  1, 0, 1, 0, 16'h0060, S_STALL);
    add("waw_t3",       0, 1, OP_MOVI, 0,  0,  6,  0,  1, 0, 1, 0, 16'h0040, S_STALL);
    add("waw_issue",    0, 1, OP_MOVI, 0,  0,  6,  0,  0, 0, 0, 1, 16'h0000, S_RUN);
    add("b_nosrc",      0, 1, OP_B,    6,  6,  6,  0,  0, 0, 0, 1, 16'h0040, S_RUN);
    add("movi_r7",      0, 1, OP_MOVI, 6,  6,  7,  0,  0, 0, 0, 1, 16'h0040, S_RUN);
    add("stall_r7",     0, 1, OP_ADD,  7,  0,  8,  0,  1, 0, 1, 0, 16'h00c0, S_STALL);
    add("br_in_stall",  0, 1, OP_ADD,  7,  0,  8,  1,  0, 1, 1, 0, 16'h0080, S_FLUSH);
    add("flush_2nd",    0, 1, OP_ADD,  7,  0,  8,  0,  0, 1, 1, 0, 16'h0080, S_FLUSH);
    add("flush_noload", 0, 0, OP_ADD,  7,  0,  8,  0,  0, 0, 0, 0, 16'h0000, S_RUN);
    add("br_idle",      0, 0, OP_ADD,  0,  0,  0,  1,  0, 1, 1, 0, 16'h0000, S_FLUSH);
    add("br_restart",   0, 0, OP_ADD,  0,  0,  0,  1,  0, 1, 1, 0, 16'h0000, S_FLUSH);
    add("restart_tail", 0, 0, OP_ADD,  0,  0,  0,  0,  0, 1, 1, 0, 16'h0000, S_FLUSH);
    add("restart_done", 0, 0, OP_ADD,  0,  0,  0,  0,  0, 0, 0, 0, 16'h0000, S_RUN);
    add("movi_r9",      0, 1, OP_MOVI, 0,  0,  9,  0,  0, 0, 0, 1, 16'h0000, S_RUN);
    add("op1110_busy",  0, 1, 4'd14,   9,  9,  9,  0,  0, 0, 0, 1, 16'h0200, S_RUN);
    add("op1110_cd1",   0, 0, 4'd14,   9,  9,  9,  0,  0, 0, 0, 0, 16'h0200, S_RUN);
    add("op1110_cd2",   0, 0, 4'd14,   9,  9,  9,  0,  0, 0, 0, 0, 16'h0200, S_RUN);
    add("op1110_cd3",   0, 0, 4'd14,   9,  9,  9,  0,  0, 0, 0, 0, 16'h0000, S_RUN);
    add("cmp_r10",      0, 1, OP_CMP,  0,  0, 10,  0,  0, 0, 0, 1, 16'h0000, S_RUN);
    add("str_rs2_raw",  0, 1, OP_STR,  0, 10, 10,  0,  1, 0, 1, 0, 16'h0400, S_STALL);
    add("lsl_no_rs2",   0, 1, OP_LSL,  0, 10, 11,  0,  0, 0, 0, 1, 16'h0400, S_RUN);
    add("stall_r11",    0, 1, OP_ADD, 11,  0, 12,  0,  1, 0, 1, 0, 16'h0c00, S_STALL);
    add("rst_in_stall", 1, 1, OP_ADD, 11,  0, 12,  0,  0, 0, 0, 0, 16'h0000, S_RUN);
    add("after_rst",    0, 1, OP_ADD, 11,  0, 12,  0,  0, 0, 0, 1, 16'h0000, S_RUN);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i].rst, tbl[i].v, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].br);
      @(negedge clk);
      check(tbl[i].name, tbl[i].stall, tbl[i].flush, tbl[i].bubble, tbl[i].iss,
            tbl[i].busy, tbl[i].st);
    end

    // Asynchronous reset in the middle of a flush with r1 and r4 pending
    @(posedge clk); #1;
    drive(1'b1, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    check("seq_rst_pulse", 0, 0, 0, 0, 16'h0000, S_RUN);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, OP_LDR, 4'd0, 4'd0, 4'd4, 1'b0);
    @(negedge clk);
    check("seq_ldr_r4", 0, 0, 0, 1, 16'h0000, S_RUN);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, OP_ADD, 4'd0, 4'd0, 4'd1, 1'b0);
    @(negedge clk);
    check("seq_add_r1", 0, 0, 0, 1, 16'h0010, S_RUN);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b1);
    @(negedge clk);
    check("seq_branch", 0, 1, 1, 0, 16'h0012, S_FLUSH);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0);
    #1;
    check("seq_mid_flush", 0, 1, 1, 0, 16'h0012, S_FLUSH);
    rst = 1'b1;
    #1;
    check("seq_async_rst", 0, 0, 0, 0, 16'h0000, S_RUN);
    drive(1'b1, 1'b1, OP_ADD, 4'd4, 4'd1, 4'd5, 1'b1);
    #1;
    check("seq_rst_gating", 0, 0, 0, 0, 16'h0000, S_RUN);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, OP_ADD, 4'd4, 4'd1, 4'd5, 1'b0);
    @(negedge clk);
    check("seq_post_rst", 0, 0, 0, 1, 16'h0000, S_RUN);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    check("seq_post_rst_load", 0, 0, 0, 0, 16'h0020, S_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
